// File: rtl/demux8_3_regbank.sv
// Eight-register bank fed by a small write queue: requests are queued and
// drained one per cycle into the register selected by a one-hot address decode.
module demux8_3_regbank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hold,
    input  logic             clr,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [2:0]       pending
);

    localparam int         SLOTS   = 4;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);

    if ((DEPTH < 2) || (DEPTH > 4)) begin : g_depth_check
        $error("demux8_3_regbank: DEPTH must be 2..4");
    end

    // Storage is sized for the largest legal depth; pointers wrap at DEPTH.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        logic [1:0] n;
        if (p == LAST_C) begin
            n = 2'd0;
        end else begin
            n = p + 2'd1;
        end
        return n;
    endfunction

    logic [2:0]       mem_addr_r [SLOTS];
    logic [WIDTH-1:0] mem_data_r [SLOTS];
    logic [WIDTH-1:0] q_r        [8];
    logic [1:0]       head_r;
    logic [1:0]       tail_r;
    logic [2:0]       count_r;

    logic             wr_ready_s;
    logic             push_s;
    logic             pop_s;
    logic [2:0]       head_addr_s;
    logic [WIDTH-1:0] head_data_s;
    logic [7:0]       dec_s;

    // Accept/drain qualification; readiness follows the registered count only.
    always_comb begin
        wr_ready_s = 1'b0;
        pop_s      = 1'b0;
        if (reset_n && !clr && (count_r < DEPTH_C)) begin
            wr_ready_s = 1'b1;
        end else begin
            wr_ready_s = 1'b0;
        end
        if (!clr && !hold && (count_r != 3'd0)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        push_s      = wr_valid && wr_ready_s;
        head_addr_s = mem_addr_r[head_r];
        head_data_s = mem_data_r[head_r];
        dec_s       = 8'b0000_0001 << head_addr_s;
    end

    // Queue slots: only written on an accepted request, so idle-bus X never enters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem_addr_r[i] <= 3'd0;
                mem_data_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_addr_r[tail_r] <= wr_addr;
            mem_data_r[tail_r] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= 2'd0;
            tail_r  <= 2'd0;
            count_r <= 3'd0;
        end else if (clr) begin
            head_r  <= 2'd0;
            tail_r  <= 2'd0;
            count_r <= 3'd0;
        end else begin
            if (push_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Register bank: the drained head lands in exactly one register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                q_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clr) begin
            for (int i = 0; i < 8; i++) begin
                q_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pop_s && dec_s[i]) begin
                    q_r[i] <= head_data_s;
                end
            end
        end
    end

    assign wr_ready = wr_ready_s;
    assign pending  = count_r;
    assign q0 = q_r[0];
    assign q1 = q_r[1];
    assign q2 = q_r[2];
    assign q3 = q_r[3];
    assign q4 = q_r[4];
    assign q5 = q_r[5];
    assign q6 = q_r[6];
    assign q7 = q_r[7];

endmodule

// File: tb/tb_demux8_3_regbank.sv
// Bench for demux8_3_regbank: table-driven vectors plus hand sequences, with a
// queue scoreboard holding accepted writes until the model drains them.
module tb_demux8_3_regbank;

    localparam int W = 16;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         wr_valid = 1'b0;
    logic [2:0]   wr_addr = 3'd0;
    logic [W-1:0] wr_data = 16'h0000;
    logic         hold = 1'b0;
    logic         clr = 1'b0;
    logic         wr_ready;
    logic [W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [2:0]   pending;

    demux8_3_regbank #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold), .clr(clr),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
        .pending(pending)
    );

    always #5 clk = ~clk;

    logic [W-1:0] dq [8];
    assign dq[0] = q0;
    assign dq[1] = q1;
    assign dq[2] = q2;
    assign dq[3] = q3;
    assign dq[4] = q4;
    assign dq[5] = q5;
    assign dq[6] = q6;
    assign dq[7] = q7;

    typedef struct {
        logic [2:0]   a;
        logic [W-1:0] d;
    } ent_t;

    typedef struct {
        bit           v;
        logic [2:0]   a;
        logic [W-1:0] d;
        bit           h;
        bit           c;
        logic [2:0]   ep;
        bit           er;
    } vec_t;

    ent_t         sb [$];
    logic [W-1:0] exp_q [8];
    vec_t         tbl [$];
    int           n_tests = 0;
    int           n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " pending"}, 32'(pending), 32'(sb.size()));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s q%0d", tag, i), 32'(dq[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < 8; i++) exp_q[i] = 16'h0000;
    endtask

    // One clock of stimulus: check readiness before the edge, then outputs after it.
    task automatic step(input bit v, input logic [2:0] a, input logic [W-1:0] d,
                        input bit h, input bit c, input bit use_exp,
                        input logic [2:0] ep, input bit er, input string tag);
        bit   rdy;
        ent_t e;
        wr_valid = v;
        wr_addr  = v ? a : 3'($urandom);
        wr_data  = v ? d : 16'($urandom);
        hold     = h;
        clr      = c;
        #1;
        rdy = reset_n && !c && (sb.size() < D);
        chk({tag, " wr_ready"}, 32'(wr_ready), 32'(rdy));
        if (use_exp) chk({tag, " wr_ready(tbl)"}, 32'(wr_ready), 32'(er));
        @(posedge clk);
        if (c) begin
            model_clear();
        end else begin
            if ((sb.size() > 0) && !h) begin
                e = sb.pop_front();
                exp_q[e.a] = e.d;
            end
            if (v && rdy) sb.push_back('{a: a, d: d});
        end
        #1;
        check_outputs(tag);
        if (use_exp) chk({tag, " pending(tbl)"}, 32'(pending), 32'(ep));
    endtask

    initial begin
        model_clear();
        // basic write to addr 5
        tbl.push_back('{1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b0, 3'd1, 1'b1});
        tbl.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1});
        // back-to-back writes to addr 7
        tbl.push_back('{1'b1, 3'd7, 16'h0001, 1'b0, 1'b0, 3'd1, 1'b1});
        tbl.push_back('{1'b1, 3'd7, 16'h0002, 1'b0, 1'b0, 3'd1, 1'b1});
        tbl.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1});
        // fill under HOLD, then release
        tbl.push_back('{1'b1, 3'd1, 16'h1111, 1'b1, 1'b0, 3'd1, 1'b1});
        tbl.push_back('{1'b1, 3'd2, 16'h2222, 1'b1, 1'b0, 3'd2, 1'b1});
        tbl.push_back('{1'b1, 3'd3, 16'h3333, 1'b1, 1'b0, 3'd2, 1'b0});
        tbl.push_back('{1'b1, 3'd3, 16'h3333, 1'b0, 1'b0, 3'd1, 1'b0});
        tbl.push_back('{1'b1, 3'd3, 16'h3333, 1'b0, 1'b0, 3'd1, 1'b1});
        tbl.push_back('{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1});

        // Reset state, before any clock edge.
        #1;
        check_outputs("reset");
        chk("reset wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].c, 1'b1,
                 tbl[i].ep, tbl[i].er, $sformatf("vec%0d", i));
        end
        chk("vec q5 final", 32'(q5), 32'h0000BEEF);
        chk("vec q7 final", 32'(q7), 32'h00000002);

        // Continuous stream to every address: one push and one pop per edge.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 16'(i * 16'h1010), 1'b0, 1'b0, 1'b1, 3'd1, 1'b1,
                 $sformatf("stream%0d", i));
        end
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, "stream_end");
        chk("stream q6", 32'(q6), 32'h00006060);

        // Clear with two entries pending and an accept offered on the same edge.
        step(1'b1, 3'd4, 16'hABCD, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "clr_pre0");
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "clr_pre1");
        chk("clr q4 before", 32'(q4), 32'h0000ABCD);
        step(1'b1, 3'd0, 16'h0F0F, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "clr_fill0");
        step(1'b1, 3'd1, 16'hF0F0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, "clr_fill1");
        step(1'b1, 3'd6, 16'h7777, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, "clr_edge");
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, "clr_after");

        // Asynchronous reset between edges with two entries queued.
        step(1'b1, 3'd2, 16'h5555, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "rst_pre0");
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "rst_pre1");
        step(1'b1, 3'd3, 16'h1234, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "rst_fill0");
        step(1'b1, 3'd4, 16'h4321, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, "rst_fill1");
        chk("rst q2 before", 32'(q2), 32'h00005555);
        wr_valid = 1'b0;
        hold     = 1'b0;
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        check_outputs("rst_async");
        chk("rst_async wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        #2;
        reset_n = 1'b1;
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, "rst_post0");
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, "rst_post1");

        // First edge after a release mid-cycle must accept.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step(1'b1, 3'd6, 16'hC0DE, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, "rel_accept");
        step(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, "rel_drain");
        chk("rel q6", 32'(q6), 32'h0000C0DE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
